// File: rtl/rotary_input_filter.sv
// Quadrature encoder front end: two-flop synchroniser and stability filter on each
// contact, then registered detent-step, direction and illegal-transition detection.
module rotary_input_filter #(
  parameter int FILTER_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic A_raw,
  input  logic B_raw,
  input  logic err_clr,
  output logic A,
  output logic B,
  output logic step,
  output logic dir,
  output logic err,
  output logic err_sticky
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {B_raw, A_raw};

  // Channel 0 is A, channel 1 is B; both channels are identical and independent.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic             filt_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            // Counter stops at CNT_LAST, so it can never wrap.
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  assign A = filt[0];
  assign B = filt[1];

  logic a_prev_reg;
  logic b_prev_reg;
  logic step_reg;
  logic dir_reg;
  logic err_reg;
  logic sticky_reg;
  logic fall_a;
  logic chg_a;
  logic chg_b;
  logic illegal;

  always_comb begin
    fall_a  = a_prev_reg & ~filt[0];
    chg_a   = a_prev_reg ^ filt[0];
    chg_b   = b_prev_reg ^ filt[1];
    illegal = chg_a & chg_b;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_prev_reg <= 1'b1;
      b_prev_reg <= 1'b1;
      step_reg   <= 1'b0;
      dir_reg    <= 1'b0;
      err_reg    <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      a_prev_reg <= filt[0];
      b_prev_reg <= filt[1];
      if (illegal) begin
        err_reg  <= 1'b1;
        step_reg <= 1'b0;
      end else if (fall_a) begin
        err_reg  <= 1'b0;
        step_reg <= 1'b1;
        dir_reg  <= filt[1];
      end else begin
        err_reg  <= 1'b0;
        step_reg <= 1'b0;
      end
      // A new error wins over a simultaneous clear request.
      if (illegal) begin
        sticky_reg <= 1'b1;
      end else if (err_clr) begin
        sticky_reg <= 1'b0;
      end
    end
  end

  assign step       = step_reg;
  assign dir        = dir_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;

endmodule

// File: tb/tb_rotary_input_filter.sv
// Directed bench for rotary_input_filter with FILTER_CYCLES=4: detents, glitches,
// illegal transitions, sticky clear and asynchronous reset behaviour.
module tb_rotary_input_filter;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic A_raw;
  logic B_raw;
  logic err_clr;
  logic A;
  logic B;
  logic step;
  logic dir;
  logic err;
  logic err_sticky;

  int tests_run = 0;
  int tests_failed = 0;

  rotary_input_filter #(.FILTER_CYCLES(4), .CNT_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .A_raw     (A_raw),
    .B_raw     (B_raw),
    .err_clr   (err_clr),
    .A         (A),
    .B         (B),
    .step      (step),
    .dir       (dir),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Watch n edges after an input change made at the preceding falling edge.
  // *_at = 0 means the event never happens within the window.
  task automatic watch(input string tag, input int n,
                       input logic a0, input logic a1, input int a_at,
                       input logic b0, input logic b1, input int b_at,
                       input int step_at, input logic dir_exp,
                       input int err_at, input int sticky_at, input logic sticky0);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s A e%0d", tag, k), A, (a_at != 0 && k >= a_at) ? a1 : a0);
      check($sformatf("%s B e%0d", tag, k), B, (b_at != 0 && k >= b_at) ? b1 : b0);
      check($sformatf("%s step e%0d", tag, k), step, k == step_at);
      check($sformatf("%s err e%0d", tag, k), err, k == err_at);
      check($sformatf("%s sticky e%0d", tag, k), err_sticky,
            (sticky_at != 0 && k >= sticky_at) ? 1'b1 : sticky0);
      if (k == step_at) check($sformatf("%s dir e%0d", tag, k), dir, dir_exp);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    A_raw   = 1'b1;
    B_raw   = 1'b1;
    err_clr = 1'b0;
    #3;
    check("rst A", A, 1'b1);
    check("rst B", B, 1'b1);
    check("rst step", step, 1'b0);
    check("rst err", err, 1'b0);
    check("rst sticky", err_sticky, 1'b0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    watch("idle", 4, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Up detent: A falls at edge 6, step with dir=1 at edge 7, held 20 cycles.
    @(negedge sys_clk); A_raw = 1'b0;
    watch("up", 20, 1, 0, 6, 1, 1, 0, 7, 1, 0, 0, 0);
    @(negedge sys_clk); A_raw = 1'b1;
    watch("up_rise", 10, 0, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0);

    // Glitches of 3 samples, single and then spaced one cycle apart.
    for (int g = 0; g < 5; g++) begin
      @(negedge sys_clk); A_raw = 1'b0;
      repeat (3) @(negedge sys_clk);
      A_raw = 1'b1;
      watch($sformatf("glitch%0d", g), 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    end
    watch("glitch_tail", 8, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Down detent: B alone falls (no event), then A falls with dir=0.
    @(negedge sys_clk); B_raw = 1'b0;
    watch("b_only", 10, 1, 1, 0, 1, 0, 6, 0, 0, 0, 0, 0);
    @(negedge sys_clk); A_raw = 1'b0;
    watch("down", 10, 1, 0, 6, 0, 0, 0, 7, 0, 0, 0, 0);
    @(negedge sys_clk); A_raw = 1'b1;
    watch("down_rise", 10, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal transition: A 1->0 and B 0->1 together.
    @(negedge sys_clk); A_raw = 1'b0; B_raw = 1'b1;
    watch("illegal", 12, 1, 0, 6, 0, 1, 6, 0, 0, 7, 7, 0);
    @(negedge sys_clk); err_clr = 1'b1;
    @(negedge sys_clk); err_clr = 1'b0;
    check("clr sticky", err_sticky, 1'b0);
    watch("after_clr", 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Second illegal transition (A 0->1, B 1->0), then async reset mid-cycle.
    @(negedge sys_clk); A_raw = 1'b1; B_raw = 1'b0;
    watch("illegal2", 9, 0, 1, 6, 1, 0, 6, 0, 0, 7, 7, 0);
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    B_raw   = 1'b1;
    #1;
    check("async A", A, 1'b1);
    check("async B", B, 1'b1);
    check("async step", step, 1'b0);
    check("async err", err, 1'b0);
    check("async sticky", err_sticky, 1'b0);
    @(negedge sys_clk); sys_rst = 1'b0;
    watch("post_rst", 4, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of qualifying an A fall: count restarts after release.
    @(negedge sys_clk); A_raw = 1'b0;
    watch("pre_rst", 3, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk); sys_rst = 1'b1;
    @(negedge sys_clk); sys_rst = 1'b0;
    watch("mid_rst", 9, 1, 0, 6, 1, 1, 0, 7, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
